uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares the single UART transmitter of the APB UART IP between several on-chip requesters. The block arbitrates round-robin at burst granularity and drives the transmitter's start/done handshake. It enforces a programmable inter-frame gap and recovers from a hung transmitter with a watchdog. It sits between the requester fabric and the UART TX core, in parallel with the APB register path.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, frame payload width
- BURST_MAX, 4, max frames per grant before forced re-arbitration (≥1)
- GAP_CYCLES, 16, idle PCLK cycles between frames (0 = none)
- TIMEOUT_CYCLES, 200000, PCLK cycles allowed from tx_start to tx_done

Ports:
- PCLK  in  1  clock; one clock, all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- enable  in  1  scheduler enable (CTRL bit0)
- req_valid  in  NUM_REQ  requester has a byte
- req_data  in  NUM_REQ*DATA_WIDTH  packed bytes, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- req_last  in  NUM_REQ  byte is last of burst
- req_ready  out  NUM_REQ  byte accepted when valid&ready
- grant  out  NUM_REQ  one-hot current owner, 0 when none
- tx_start  out  1  one-cycle start pulse to UART TX
- tx_data  out  DATA_WIDTH  byte for UART TX, stable from tx_start until next accept
- tx_busy  in  1  UART TX frame in progress
- tx_done  in  1  one-cycle frame-complete pulse
- tx_rst  out  1  one-cycle UART TX reset pulse on timeout
- err_clr  in  1  clears timeout_err
- timeout_err  out  1  sticky watchdog flag
- frames_sent  out  16  completed-frame counter

## Operation
- States: IDLE, ARB, LAUNCH, START, WAIT, GAP.
- IDLE: leave for ARB when enable=1.
- ARB: pick the first valid requester at or after rr_ptr, with wrap. Set grant one-hot, clear burst_cnt, go to LAUNCH. No valid requester: stay in ARB. enable=0: go to IDLE.
- LAUNCH:
  - req_ready[g]=1 for the granted requester only.
  - On valid&ready: capture the byte into tx_data, latch req_last, burst_cnt++, go to START.
  - If req_valid[g]=0 and burst_cnt>0: release the grant, rr_ptr=g+1, go to ARB.
- START: wait until tx_busy=0. Then pulse tx_start, clear the watchdog counter, go to WAIT.
- WAIT:
  - On tx_done: frames_sent++ (wraps FFFF→0000), go to GAP.
  - If the watchdog reaches TIMEOUT_CYCLES first: pulse tx_rst, set timeout_err, abort the burst (release the grant, rr_ptr=g+1), go to GAP.
- GAP:
  - Count GAP_CYCLES, or leave next cycle if GAP_CYCLES=0.
  - If the burst continues (no last, burst_cnt<BURST_MAX, enable=1): go to LAUNCH.
  - Otherwise: release the grant, rr_ptr=g+1 mod NUM_REQ, go to ARB (or IDLE if enable=0).
- enable deasserted mid-burst: the current frame and gap complete, then IDLE. No new byte is accepted.
- Simultaneous events:
  - tx_done in the same cycle as watchdog expiry counts as done: no error, no tx_rst.
  - err_clr in the same cycle as a new timeout: set wins.
- PRESET mid-operation: abandon any frame immediately. tx_rst is not pulsed, because the UART has its own reset.

## Timing
- Reset values: req_ready=0, grant=0, tx_start=0, tx_data=0, tx_rst=0, timeout_err=0, frames_sent=0. rr_ptr=0, state=IDLE.
- Accept cycle N (LAUNCH handshake) → tx_data valid at N+1. tx_start=1 at N+1 if tx_busy=0, else in the first cycle after tx_busy falls.
- ARB→grant visible: 1 cycle after entering ARB. req_ready rises the cycle after grant.
- Minimum frame-to-frame spacing within a burst: tx_done at cycle D → next req_ready at D+GAP_CYCLES+1.
- Watchdog: counts PCLK cycles in WAIT starting the cycle after tx_start. Expires when count == TIMEOUT_CYCLES−1. tx_rst is high exactly one cycle.
- All outputs are registered except req_ready, which is decoded from state and grant.

## Structure
- Package uart_sched_pkg holds the state enum (3-bit encoding) and the default GAP_CYCLES/TIMEOUT_CYCLES constants. It also holds the clog2-derived widths for rr_ptr and the counters.
- Sub-module rr_arbiter: inputs are the request vector and rr_ptr; output is the one-hot winner. Purely combinational, instantiated once.
- Top level holds the FSM, watchdog, gap/burst counters, tx_data register and frames_sent counter.

## Test plan
- Single requester: req 0 sends 0x55 with last=1, UART model asserts tx_done 1000 cycles after tx_start → tx_data=0x55, one tx_start, frames_sent=1, grant returns to 0.
- Round-robin: reqs 0, 1 and 2 each hold valid with last=1 → grants in order 0,1,2,0. Each tx_start is separated by ≥GAP_CYCLES after the prior tx_done.
- Burst limit: req 1 streams 6 bytes with no last, BURST_MAX=4, req 2 waiting → 4 frames from req 1, then grant to req 2, then req 1 resumes.
- Watchdog: UART model never asserts tx_done → tx_rst pulse at TIMEOUT_CYCLES, timeout_err=1, grant moves to the next requester. err_clr clears the flag. A later tx_done arriving on the expiry cycle produces no error.
- Enable drop: deassert enable during WAIT of burst frame 2 → frame 2 completes, no frame 3 is accepted, state returns to IDLE, req_ready stays 0.
- Reset mid-frame: PRESET high for 1 cycle during WAIT → all outputs reach their reset values on the next edge, and frames_sent=0.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types and sizing helpers for the UART TX scheduler.
// The state encoding is exposed on the debug port, so keep it stable.
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_GAP    = 3'd5
    } sched_state_e;

    localparam int DEFAULT_NUM_REQ        = 4;
    localparam int DEFAULT_GAP_CYCLES     = 16;
    localparam int DEFAULT_TIMEOUT_CYCLES = 200000;

    // Bits needed to hold any value in 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int RR_PTR_W  = cnt_width(DEFAULT_NUM_REQ - 1);
    localparam int GAP_CNT_W = cnt_width(DEFAULT_GAP_CYCLES);
    localparam int WDOG_W    = cnt_width(DEFAULT_TIMEOUT_CYCLES);

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester-fabric and UART-TX handshake bundle seen by the scheduler.
// Handshake: a requester byte transfers in any cycle where req_valid[i] and
// req_ready[i] are both high; req_valid/data/last must hold until then.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            grant;
    logic                          tx_start;
    logic [DATA_WIDTH-1:0]         tx_data;
    logic                          tx_busy;
    logic                          tx_done;
    logic                          tx_rst;

    modport master (
        input  req_valid, req_data, req_last, tx_busy, tx_done,
        output req_ready, grant, tx_start, tx_data, tx_rst
    );

    modport slave (
        output req_valid, req_data, req_last, tx_busy, tx_done,
        input  req_ready, grant, tx_start, tx_data, tx_rst
    );
endinterface

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr,
// otherwise the lowest set request (wrap-around).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner
);
    logic [NUM_REQ-1:0] hi_pick;
    logic [NUM_REQ-1:0] lo_pick;
    logic               hi_found;
    logic               lo_found;

    always_comb begin
        hi_pick  = '0;
        lo_pick  = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i] && !lo_found) begin
                lo_pick[i] = 1'b1;
                lo_found   = 1'b1;
            end
            if (req[i] && (i >= int'(rr_ptr)) && !hi_found) begin
                hi_pick[i] = 1'b1;
                hi_found   = 1'b1;
            end
        end
        winner = hi_found ? hi_pick : lo_pick;
    end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ requesters: burst-level
// round-robin, start/done handshake, inter-frame gap and a TX watchdog.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int DATA_WIDTH     = 8,
    parameter int BURST_MAX      = 4,
    parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   enable,
    input  logic                   err_clr,
    uart_tx_scheduler_if.master    bus,
    output logic                   timeout_err,
    output logic [15:0]            frames_sent,
    output sched_state_e           state_dbg
);
    localparam int PTR_W   = cnt_width(NUM_REQ - 1);
    localparam int BURST_W = cnt_width(BURST_MAX);
    localparam int GAP_W   = cnt_width(GAP_CYCLES);
    localparam int WD_W    = cnt_width(TIMEOUT_CYCLES);

    sched_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [BURST_W-1:0]    burst_q, burst_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [WD_W-1:0]       wdog_q, wdog_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  last_q, last_d;
    logic                  tx_start_q, tx_start_d;
    logic                  tx_rst_q, tx_rst_d;
    logic                  err_q, err_d;
    logic [15:0]           frames_q, frames_d;

    logic [NUM_REQ-1:0]    arb_winner;
    logic [PTR_W-1:0]      g_idx;
    logic [PTR_W-1:0]      next_ptr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  gap_over;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_arb (
        .req    (bus.req_valid),
        .rr_ptr (rr_ptr_q),
        .winner (arb_winner)
    );

    // Decode of the current owner: index, successor pointer and its byte.
    always_comb begin
        g_idx    = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx    = PTR_W'(i);
                sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        next_ptr  = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + PTR_W'(1);
        sel_valid = |(bus.req_valid & grant_q);
        sel_last  = |(bus.req_last & grant_q);
        gap_over  = (GAP_CYCLES == 0) || (gap_q == GAP_W'(GAP_CYCLES - 1));
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        burst_d    = burst_q;
        gap_d      = gap_q;
        wdog_d     = wdog_q;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        tx_start_d = 1'b0;
        tx_rst_d   = 1'b0;
        err_d      = err_clr ? 1'b0 : err_q;
        frames_d   = frames_q;

        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_ARB;
            end
            ST_ARB: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (|arb_winner) begin
                    grant_d = arb_winner;
                    burst_d = '0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                if (!enable) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_IDLE;
                end else if (sel_valid) begin
                    tx_data_d = sel_data;
                    last_d    = sel_last;
                    burst_d   = burst_q + BURST_W'(1);
                    wdog_d    = '0;
                    // Skip START when the transmitter is already free so
                    // tx_start lines up with tx_data on the next cycle.
                    if (!bus.tx_busy) begin
                        tx_start_d = 1'b1;
                        state_d    = ST_WAIT;
                    end else begin
                        state_d = ST_START;
                    end
                end else if (burst_q != '0) begin
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    state_d  = ST_ARB;
                end
            end
            ST_START: begin
                if (!bus.tx_busy) begin
                    tx_start_d = 1'b1;
                    wdog_d     = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wdog_d = wdog_q + WD_W'(1);
                if (bus.tx_done) begin
                    frames_d = frames_q + 16'd1;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    tx_rst_d = 1'b1;
                    err_d    = 1'b1;
                    grant_d  = '0;
                    rr_ptr_d = next_ptr;
                    gap_d    = '0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_over) begin
                    // A zero grant here means the burst was aborted by the watchdog.
                    if ((grant_q != '0) && !last_q &&
                        (burst_q < BURST_W'(BURST_MAX)) && enable) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        if (grant_q != '0) begin
                            grant_d  = '0;
                            rr_ptr_d = next_ptr;
                        end
                        state_d = enable ? ST_ARB : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            burst_q    <= '0;
            gap_q      <= '0;
            wdog_q     <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_rst_q   <= 1'b0;
            err_q      <= 1'b0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            burst_q    <= burst_d;
            gap_q      <= gap_d;
            wdog_q     <= wdog_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            tx_start_q <= tx_start_d;
            tx_rst_q   <= tx_rst_d;
            err_q      <= err_d;
            frames_q   <= frames_d;
        end
    end

    assign bus.req_ready = (state_q == ST_LAUNCH && enable) ? grant_q : '0;
    assign bus.grant     = grant_q;
    assign bus.tx_start  = tx_start_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.tx_rst    = tx_rst_q;
    assign timeout_err   = err_q;
    assign frames_sent   = frames_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: requester queues, a UART TX model
// with programmable done latency, and a scoreboard of expected frames.
module tb_uart_tx_scheduler;
    import uart_sched_pkg::*;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int BM  = 4;
    localparam int GAP = 6;
    localparam int TO  = 1200;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         err_clr;
    logic         timeout_err;
    logic [15:0]  frames_sent;
    sched_state_e state_dbg;

    uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    uart_tx_scheduler #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM),
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK        (clk),
        .PRESET      (rst),
        .enable      (enable),
        .err_clr     (err_clr),
        .bus         (bus),
        .timeout_err (timeout_err),
        .frames_sent (frames_sent),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests_run = 0;
    int fail_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- requester model ----------------
    logic [DW:0] rq_mem [NR][32];
    int          rq_head [NR];
    int          rq_tail [NR];

    task automatic add_req(input int id, input logic last, input logic [DW-1:0] d);
        rq_mem[id][rq_tail[id]] = {last, d};
        rq_tail[id]++;
    endtask

    initial begin
        logic [NR-1:0] acc;
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        forever begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && rq_head[i] != rq_tail[i]) rq_head[i]++;
                bus.req_valid[i] = (rq_head[i] != rq_tail[i]);
                bus.req_last[i]  = rq_mem[rq_head[i]%32 == rq_head[i] ? i : i][rq_head[i]][DW];
                bus.req_data[i*DW +: DW] = rq_mem[i][rq_head[i]][DW-1:0];
            end
        end
    end

    // ---------------- UART TX model ----------------
    int uart_delay = 20;   // 0 = never completes

    initial begin
        int cnt;
        cnt = 0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_done = 1'b0;
            if (rst || bus.tx_rst) begin
                cnt = 0;
                bus.tx_busy = 1'b0;
            end else begin
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        bus.tx_done = 1'b1;
                        bus.tx_busy = 1'b0;
                    end
                end
                if (bus.tx_start) begin
                    bus.tx_busy = 1'b1;
                    cnt = uart_delay;
                end
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [15:0] exp_q[$];
    int start_cnt = 0;
    int rst_cnt   = 0;
    int last_start = 0;
    int last_done  = 0;
    bit done_seen  = 1'b0;

    function automatic logic [7:0] gidx(input logic [NR-1:0] g);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = 0; i < NR; i++) if (g[i]) r = 8'(i);
        return r;
    endfunction

    task automatic exp_push(input int id, input logic [DW-1:0] d);
        exp_q.push_back({8'(id), d});
    endtask

    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (bus.tx_start) begin
                start_cnt++;
                last_start = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_start", {8'(gidx(bus.grant)), bus.tx_data}, 16'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_owner_data", {8'(gidx(bus.grant)), bus.tx_data}, e);
                end
                if (done_seen) check("gap_after_done", (cyc - last_done) > GAP, 1);
            end
            if (bus.tx_done) begin
                last_done = cyc;
                done_seen = 1'b1;
            end
            if (bus.tx_rst) begin
                rst_cnt++;
                check("txrst_latency", cyc - last_start, TO);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        enable = 1'b0;
        err_clr = 1'b0;
        clear_reqs();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_cnt = 0;
        rst_cnt = 0;
        done_seen = 1'b0;
    endtask

    task automatic check_reset(input string p);
        check({p, "_req_ready"}, bus.req_ready, 0);
        check({p, "_grant"}, bus.grant, 0);
        check({p, "_tx_start"}, bus.tx_start, 0);
        check({p, "_tx_data"}, bus.tx_data, 0);
        check({p, "_tx_rst"}, bus.tx_rst, 0);
        check({p, "_timeout_err"}, timeout_err, 0);
        check({p, "_frames_sent"}, frames_sent, 0);
        check({p, "_state"}, state_dbg, ST_IDLE);
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int k = 0;
        while (int'(frames_sent) < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, int'(frames_sent) >= n, 1);
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (start_cnt < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, start_cnt >= n, 1);
    endtask

    task automatic wait_txrst(input int budget, input string tag);
        int k = 0;
        while (bus.tx_rst !== 1'b1 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check(tag, bus.tx_rst, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] d1 [6];
        logic [DW-1:0] d;
        logic [NR-1:0] ready_seen;

        rst = 1'b1;
        enable = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst0");

        // Single requester, long frame
        reset_dut();
        uart_delay = 1000;
        add_req(0, 1'b1, 8'h55);
        exp_push(0, 8'h55);
        enable = 1'b1;
        wait_frames(1, 3000, "t1_done");
        repeat (GAP + 4) @(posedge clk);
        #1;
        check("t1_frames", frames_sent, 1);
        check("t1_starts", start_cnt, 1);
        check("t1_grant", bus.grant, 0);
        check("t1_tx_data", bus.tx_data, 8'h55);
        check("t1_expq", exp_q.size(), 0);

        // Round-robin over three requesters
        reset_dut();
        uart_delay = 20;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            add_req(i, 1'b1, d);
            exp_push(i, d);
        end
        d = 8'($urandom_range(0, 255));
        add_req(0, 1'b1, d);
        exp_push(0, d);
        enable = 1'b1;
        wait_frames(4, 2000, "t2_done");
        repeat (GAP + 4) @(posedge clk);
        #1;
        check("t2_starts", start_cnt, 4);
        check("t2_grant", bus.grant, 0);
        check("t2_expq", exp_q.size(), 0);

        // Burst limit with a waiting requester
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            d1[k] = 8'($urandom_range(0, 255));
            add_req(1, 1'b0, d1[k]);
        end
        d = 8'($urandom_range(0, 255));
        add_req(2, 1'b1, d);
        for (int k = 0; k < 4; k++) exp_push(1, d1[k]);
        exp_push(2, d);
        exp_push(1, d1[4]);
        exp_push(1, d1[5]);
        enable = 1'b1;
        wait_frames(7, 3000, "t3_done");
        repeat (GAP + 6) @(posedge clk);
        #1;
        check("t3_starts", start_cnt, 7);
        check("t3_expq", exp_q.size(), 0);
        check("t3_grant", bus.grant, 0);
        check("t3_state", state_dbg, ST_ARB);

        // Watchdog expiry, err_clr, and done on the expiry cycle
        reset_dut();
        uart_delay = 0;
        d = 8'($urandom_range(0, 255));
        add_req(0, 1'b1, d);
        exp_push(0, d);
        d = 8'($urandom_range(0, 255));
        add_req(1, 1'b1, d);
        exp_push(1, d);
        enable = 1'b1;
        wait_txrst(TO + 200, "t4_txrst_seen");
        check("t4_err_set", timeout_err, 1);
        check("t4_frames0", frames_sent, 0);
        check("t4_grant_released", bus.grant, 0);
        uart_delay = 20;
        @(posedge clk);
        #1;
        check("t4_txrst_one_cycle", bus.tx_rst, 0);
        wait_frames(1, 500, "t4_next_done");
        check("t4_err_sticky", timeout_err, 1);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("t4_err_cleared", timeout_err, 0);
        uart_delay = TO - 1;
        d = 8'($urandom_range(0, 255));
        add_req(2, 1'b1, d);
        exp_push(2, d);
        wait_frames(2, TO + 300, "t4_coinc_done");
        repeat (3) @(posedge clk);
        #1;
        check("t4_coinc_err", timeout_err, 0);
        check("t4_rst_cnt", rst_cnt, 1);
        check("t4_expq", exp_q.size(), 0);

        // Enable dropped during WAIT of burst frame 2
        reset_dut();
        uart_delay = 50;
        for (int k = 0; k < 3; k++) begin
            d1[k] = 8'($urandom_range(0, 255));
            add_req(3, 1'b0, d1[k]);
        end
        exp_push(3, d1[0]);
        exp_push(3, d1[1]);
        enable = 1'b1;
        wait_starts(2, 1000, "t5_two_starts");
        check("t5_in_wait", state_dbg, ST_WAIT);
        enable = 1'b0;
        wait_frames(2, 500, "t5_frame2_done");
        repeat (GAP + 4) @(posedge clk);
        #1;
        check("t5_state_idle", state_dbg, ST_IDLE);
        check("t5_grant", bus.grant, 0);
        ready_seen = '0;
        repeat (20) begin
            @(posedge clk);
            #1;
            ready_seen |= bus.req_ready;
        end
        check("t5_ready_low", ready_seen, 0);
        check("t5_starts", start_cnt, 2);
        check("t5_frames", frames_sent, 2);
        clear_reqs();

        // Reset in the middle of a frame (frames_sent is 2 going in)
        uart_delay = 100;
        d = 8'($urandom_range(0, 255));
        add_req(0, 1'b1, d);
        exp_push(0, d);
        enable = 1'b1;
        wait_starts(3, 500, "t6_start");
        repeat (10) @(posedge clk);
        #1;
        check("t6_in_wait", state_dbg, ST_WAIT);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("t6");
        rst = 1'b0;
        enable = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end
endmodule
